// File: rtl/sms_pow_seq.sv
// Constant-time GF(2^N) power map y = x^e, MSB-first square-and-multiply, one exponent bit per clock (N-cycle latency).
// Valid/ready on both sides; holds result under backpressure. Optional affine parity term under SMS_POW_AFFINE_EN.
module sms_pow_seq #(
  parameter int unsigned    N        = 6,
  parameter logic [N:0]     POLY     = 7'b1000011,
  parameter logic [N-1:0]   AFF_MASK = 6'b010100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_x,
  input  logic [N-1:0] in_e,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

`ifdef SMS_POW_AFFINE_EN
  localparam logic AFF_EN = 1'b1;
`else
  localparam logic AFF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   x_r_q, x_r_d;
  logic [N-1:0]   e_r_q, e_r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   out_y_q, out_y_d;

  logic [N-1:0]   acc_sq;
  logic [N-1:0]   mul_op;
  logic [N-1:0]   acc_step;
  logic           aff_t;

  // Shift-and-add multiply; the partial multiplicand is reduced by POLY each step.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] p;
    logic [N-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < int'(N); i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[N-1] ? ((aa << 1) ^ POLY[N-1:0]) : (aa << 1);
    end
    return p;
  endfunction

  // Multiply by x or by 1 is always evaluated so every RUN cycle costs the same.
  always_comb begin
    acc_sq   = gf_mul(acc_q, acc_q);
    mul_op   = e_r_q[cnt_q] ? x_r_q : ONE;
    acc_step = gf_mul(acc_sq, mul_op);
    aff_t    = (^(x_r_q & AFF_MASK)) & AFF_EN;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_r_d     = x_r_q;
    e_r_d     = e_r_q;
    cnt_d     = cnt_q;
    out_y_d   = out_y_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_r_d   = in_x;
          e_r_d   = in_e;
          acc_d   = ONE;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          out_y_d = acc_step ^ {N{aff_t}};
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      x_r_q   <= '0;
      e_r_q   <= '0;
      cnt_q   <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_r_q   <= x_r_d;
      e_r_q   <= e_r_d;
      cnt_q   <= cnt_d;
      out_y_q <= out_y_d;
    end
  end

  assign out_y = out_y_q;

endmodule

// File: tb/tb_sms_pow_seq.sv
// Scoreboard bench for sms_pow_seq (N=6, x^6+x+1): directed vectors, backpressure, mid-run reset, full 64x64 sweep.
module tb_sms_pow_seq;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_x = '0;
  logic [5:0] in_e = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] out_y;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];
  int acc_edge_q[$];
  logic prev_v = 1'b0;

  sms_pow_seq #(.N(6), .POLY(7'b1000011), .AFF_MASK(6'b010100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_e(in_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Full carry-less product, then reduce the high bits by x^6+x+1.
  function automatic int ref_mul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (a << i);
    for (int i = 10; i >= 6; i--) if (p[i]) p = p ^ (7'b1000011 << (i - 6));
    return p & 63;
  endfunction

  function automatic int aff_adj(input int x, input int y);
    int m;
    m = x & 6'b010100;
`ifdef SMS_POW_AFFINE_EN
    return (^m[5:0]) ? (y ^ 63) : y;
`else
    return y + (m & 0);
`endif
  endfunction

  // Repeated multiplication, independent of the square-and-multiply structure.
  function automatic int ref_pow(input int x, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return aff_adj(x, r);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int x, input int e, input int y_exp);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("issue_wait_in_ready", 0, 1);
    end else begin
      in_x = 6'(x);
      in_e = 6'(e);
      in_valid = 1'b1;
      exp_q.push_back(y_exp);
      acc_edge_q.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_x = 6'($urandom);
      in_e = 6'($urandom);
    end
  endtask

  // Monitor: each new out_valid pops one expectation and checks value and latency.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(out_y), -1);
        end else begin
          int y_e;
          int a_e;
          y_e = exp_q.pop_front();
          a_e = acc_edge_q.pop_front();
          check("out_y", int'(out_y), y_e);
          check("latency", cyc - a_e, N);
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_y", int'(out_y), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(2, 6, aff_adj(2, 3));
    issue(2, 7, aff_adj(2, 6));
    issue(2, 62, aff_adj(2, 33));
    issue(0, 0, aff_adj(0, 1));
    issue(0, 5, aff_adj(0, 0));
    issue(37, 63, aff_adj(37, 1));
`ifdef SMS_POW_AFFINE_EN
    issue(4, 1, 59);
`else
    issue(4, 1, 4);
`endif

    // Backpressure: result held, no accept while DONE.
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    issue(9, 10, ref_pow(9, 10));
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid", int'(out_valid), 1);
    in_valid = 1'b1;
    in_x = 6'd2;
    in_e = 6'd7;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_y_stable", int'(out_y), ref_pow(9, 10));
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_valid_held", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    issue(2, 7, aff_adj(2, 6));

    // Reset three cycles into RUN discards the in-flight result.
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_x = 6'd7;
    in_e = 6'd13;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_y", int'(out_y), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2, 6, aff_adj(2, 3));

    // Full sweep against the reference model.
    for (int x = 0; x < 64; x++) begin
      for (int e = 0; e < 64; e++) begin
        issue(x, e, ref_pow(x, e));
      end
    end

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
